// File: rtl/lz77_pkg.sv
// Shared LZ77 definitions for the encoder/decoder pair: field widths, window limits, terminator literal and decoder states.
package lz77_pkg;

    localparam int LZ77_OFF_W        = 5;
    localparam int LZ77_LEN_W        = 5;
    localparam int LZ77_CHAR_W       = 8;
    localparam int LZ77_SEARCH_DEPTH = 30;
    localparam int LZ77_MAX_MATCH    = 24;
    localparam logic [LZ77_CHAR_W-1:0] LZ77_TERM_CHAR = 8'h24;

    typedef enum logic [1:0] {
        IDLE,
        COPY,
        LIT,
        DONE
    } lz77_state_t;

    function automatic logic is_term(input logic [LZ77_CHAR_W-1:0] c);
        return c == LZ77_TERM_CHAR;
    endfunction

endpackage

// File: rtl/lz77_decoder_if.sv
// Code-in / char-out bundle of the LZ77 decoder; slave is the decoder side, master the source/sink side.
interface lz77_decoder_if;
    import lz77_pkg::*;

    logic                   code_valid;
    logic                   code_ready;
    logic [LZ77_OFF_W-1:0]  offset;
    logic [LZ77_LEN_W-1:0]  match_len;
    logic [LZ77_CHAR_W-1:0] char_nxt;
    logic                   out_valid;
    logic [LZ77_CHAR_W-1:0] out_char;
    logic                   finish;
    logic                   protocol_err;

    modport master (
        output code_valid, offset, match_len, char_nxt,
        input  code_ready, out_valid, out_char, finish, protocol_err
    );

    modport slave (
        input  code_valid, offset, match_len, char_nxt,
        output code_ready, out_valid, out_char, finish, protocol_err
    );

endinterface

// File: rtl/lz77_hist_shreg.sv
// History window for the LZ77 decoder: a shift register of emitted chars with one indexed read port.
module lz77_hist_shreg #(
    parameter int DEPTH  = 30,
    parameter int CHAR_W = 8,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en,
    input  logic [CHAR_W-1:0] din,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [CHAR_W-1:0] rd_data
);

    logic [CHAR_W-1:0] hist [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
        end else if (shift_en) begin
            hist[0] <= din;
            for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
        end
    end

    // Indices past the window end read as zero rather than aliasing.
    always_comb begin
        rd_data = '0;
        if (int'(rd_idx) < DEPTH) rd_data = hist[rd_idx];
    end

endmodule

// File: rtl/lz77_decoder.sv
// LZ77 decoder: expands (offset, match_len, char_nxt) codes into a char stream until the '$' terminator.
// Define LZ77_DEC_CHECK_EN to build the sticky protocol_err checker; otherwise protocol_err is tied low.
module lz77_decoder
    import lz77_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    lz77_decoder_if.slave bus
);

    lz77_state_t            state, state_nxt;
    logic [LZ77_OFF_W-1:0]  offset_r;
    logic [LZ77_LEN_W-1:0]  cnt_r;
    logic [LZ77_CHAR_W-1:0] char_r;
    logic [LZ77_CHAR_W-1:0] hist_data;
    logic [LZ77_CHAR_W-1:0] out_char_c;
    logic                   out_valid_c;
    logic                   code_ready_c;
    logic                   accept;
    logic                   protocol_err_r;
    lz77_state_t            entry_state;

    assign code_ready_c = (state == IDLE) || (state == LIT);
    assign accept       = bus.code_valid && code_ready_c;

    // A fresh code starts copying, or goes straight to its literal, or ends the stream if it is a bare terminator.
    assign entry_state = (bus.match_len != '0)  ? COPY :
                         is_term(bus.char_nxt)  ? DONE : LIT;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        out_valid_c = 1'b0;
        out_char_c  = '0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = entry_state;
            end
            COPY: begin
                out_valid_c = 1'b1;
                out_char_c  = hist_data;
                if (cnt_r == 5'd1) state_nxt = is_term(char_r) ? DONE : LIT;
            end
            LIT: begin
                out_valid_c = 1'b1;
                out_char_c  = char_r;
                state_nxt   = accept ? entry_state : IDLE;
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            offset_r <= '0;
            cnt_r    <= '0;
            char_r   <= '0;
        end else if (accept) begin
            offset_r <= bus.offset;
            cnt_r    <= bus.match_len;
            char_r   <= bus.char_nxt;
        end else if (state == COPY) begin
            cnt_r <= cnt_r - 5'd1;
        end
    end

    lz77_hist_shreg #(
        .DEPTH  (LZ77_SEARCH_DEPTH),
        .CHAR_W (LZ77_CHAR_W),
        .IDX_W  (LZ77_OFF_W)
    ) u_hist (
        .clk      (clk),
        .reset    (reset),
        .shift_en (out_valid_c),
        .din      (out_char_c),
        .rd_idx   (offset_r),
        .rd_data  (hist_data)
    );

`ifdef LZ77_DEC_CHECK_EN
    // Flags out-of-range code fields and any code offered after the stream has ended.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            protocol_err_r <= 1'b0;
        end else if ((accept && ((int'(bus.offset) >= LZ77_SEARCH_DEPTH) ||
                                 (int'(bus.match_len) > LZ77_MAX_MATCH))) ||
                     ((state == DONE) && bus.code_valid)) begin
            protocol_err_r <= 1'b1;
        end
    end
`else
    assign protocol_err_r = 1'b0;
`endif

    assign bus.code_ready   = code_ready_c;
    assign bus.out_valid    = out_valid_c;
    assign bus.out_char     = out_char_c;
    assign bus.finish       = (state == DONE);
    assign bus.protocol_err = protocol_err_r;

endmodule
